// File: rtl/weight_fetch_pkg.sv
// rtl/weight_fetch_pkg.sv - shared types and defaults for the weight ROM fetch sequencer
// Purpose: sequencer state encoding, tile command shape and default geometry.
// Ports: none (package). Optional feature macro used by the top: WEIGHT_FETCH_PERF_EN.
package weight_fetch_pkg;

   localparam int DEF_ROWS   = 64;
   localparam int DEF_COLS   = 64;
   localparam int DEF_NUM_CH = 10;
   localparam int DEF_W      = 32;
   localparam int DEF_A      = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [DEF_A-1:0] ch;
      logic [DEF_A-1:0] row_base;
      logic [DEF_A-1:0] col_base;
      logic [DEF_A-1:0] rows;
      logic [DEF_A-1:0] cols;
   } tile_cmd_t;

endpackage

// File: rtl/tile_addr_counter.sv
// rtl/tile_addr_counter.sv - row-major 2-D tile address counter with base wrap
// Purpose: walks a rows x cols tile starting at (row_base, col_base), column fastest.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   i_load                   capture bases/extent and restart at the tile origin
//   i_adv                    step to the next address (ignored while i_load)
//   i_row_base, i_col_base   tile origin
//   i_rows, i_cols           tile extent, both >= 1
//   o_row, o_col             current ROM row/column address
//   o_last                   current address is the final word of the tile
module tile_addr_counter
   import weight_fetch_pkg::*;
#(
   parameter int A = DEF_A
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic         i_adv,
   input  logic [A-1:0] i_row_base,
   input  logic [A-1:0] i_col_base,
   input  logic [A-1:0] i_rows,
   input  logic [A-1:0] i_cols,
   output logic [A-1:0] o_row,
   output logic [A-1:0] o_col,
   output logic         o_last
);

   logic [A-1:0] r_row;
   logic [A-1:0] r_col;
   logic [A-1:0] r_col_base;
   logic [A-1:0] r_row_cnt;
   logic [A-1:0] r_col_cnt;
   logic [A-1:0] r_rows_m1;
   logic [A-1:0] r_cols_m1;
   logic         w_row_end;

   // Extents are stored minus one so the end tests are plain equality.
   assign w_row_end = (r_col_cnt == r_cols_m1);
   assign o_last    = (r_row_cnt == r_rows_m1) && w_row_end;
   assign o_row     = r_row;
   assign o_col     = r_col;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_row      <= '0;
         r_col      <= '0;
         r_col_base <= '0;
         r_row_cnt  <= '0;
         r_col_cnt  <= '0;
         r_rows_m1  <= '0;
         r_cols_m1  <= '0;
      end else if (i_load) begin
         r_row      <= i_row_base;
         r_col      <= i_col_base;
         r_col_base <= i_col_base;
         r_row_cnt  <= '0;
         r_col_cnt  <= '0;
         r_rows_m1  <= i_rows - 1'b1;
         r_cols_m1  <= i_cols - 1'b1;
      end else if (i_adv) begin
         if (w_row_end) begin
            r_col_cnt <= '0;
            r_col     <= r_col_base;
            r_row_cnt <= r_row_cnt + 1'b1;
            r_row     <= r_row + 1'b1;
         end else begin
            r_col_cnt <= r_col_cnt + 1'b1;
            r_col     <= r_col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/weight_rom_fetch_sequencer.sv
// rtl/weight_rom_fetch_sequencer.sv - streams a rectangular weight tile out of a combinational ROM
// Purpose: accepts a tile command, validates it, walks the ROM row-major and delivers each
//   word over a valid/ready stream, then pulses done.
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   cmd_valid/cmd_ready                 tile command handshake (ready only when idle)
//   cmd_ch, cmd_row_base, cmd_col_base  ROM channel and tile origin
//   cmd_rows, cmd_cols                  tile extent, 1..ROWS / 1..COLS
//   rom_ch, rom_row, rom_col, rom_data  ROM address out, data back in the same cycle
//   out_valid/out_ready/out_data/out_last  weight word stream
//   done                                one-cycle pulse after the last word is taken
//   cmd_err                             one-cycle pulse on a rejected command
//   busy                                tile in flight (FETCH or DRAIN)
//   perf_stall_cnt, perf_tile_cnt       only with WEIGHT_FETCH_PERF_EN: saturating counters
module weight_rom_fetch_sequencer
   import weight_fetch_pkg::*;
#(
   parameter int ROWS   = DEF_ROWS,
   parameter int COLS   = DEF_COLS,
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int W      = DEF_W,
   parameter int A      = DEF_A
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [A-1:0] cmd_ch,
   input  logic [A-1:0] cmd_row_base,
   input  logic [A-1:0] cmd_col_base,
   input  logic [A-1:0] cmd_rows,
   input  logic [A-1:0] cmd_cols,
   output logic [A-1:0] rom_ch,
   output logic [A-1:0] rom_row,
   output logic [A-1:0] rom_col,
   input  logic [W-1:0] rom_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         done,
   output logic         cmd_err,
`ifdef WEIGHT_FETCH_PERF_EN
   output logic [31:0]  perf_stall_cnt,
   output logic [15:0]  perf_tile_cnt,
`endif
   output logic         busy
);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_FETCH = ST_FETCH;
   localparam logic [1:0] S_DRAIN = ST_DRAIN;
   localparam logic [1:0] S_DONE  = ST_DONE;

   localparam logic [A:0] ROWS_X   = (A+1)'(ROWS);
   localparam logic [A:0] COLS_X   = (A+1)'(COLS);
   localparam logic [A:0] NUM_CH_X = (A+1)'(NUM_CH);

   logic [1:0]   r_state;
   logic [A-1:0] r_rom_ch;
   logic         r_out_valid;
   logic [W-1:0] r_out_data;
   logic         r_out_last;
   logic         r_done;
   logic         r_cmd_err;

   logic [A:0]   w_row_end;
   logic [A:0]   w_col_end;
   logic         w_bad;
   logic         w_accept;
   logic         w_adv;
   logic         w_last;
   logic         w_ctr_adv;

   // One extra bit so base + extent cannot wrap past the ROM bound.
   assign w_row_end = {1'b0, cmd_row_base} + {1'b0, cmd_rows};
   assign w_col_end = {1'b0, cmd_col_base} + {1'b0, cmd_cols};
   assign w_bad     = (cmd_rows == '0) || (cmd_cols == '0) ||
                      ({1'b0, cmd_ch} >= NUM_CH_X) ||
                      (w_row_end > ROWS_X) || (w_col_end > COLS_X);

   assign w_accept  = (r_state == S_IDLE) && cmd_valid && !w_bad;
   assign w_adv     = !r_out_valid || out_ready;
   // The final address is held once issued so the stalled word keeps its source.
   assign w_ctr_adv = (r_state == S_FETCH) && w_adv && !w_last;

   tile_addr_counter #(.A(A)) u_addr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_accept),
      .i_adv      (w_ctr_adv),
      .i_row_base (cmd_row_base),
      .i_col_base (cmd_col_base),
      .i_rows     (cmd_rows),
      .i_cols     (cmd_cols),
      .o_row      (rom_row),
      .o_col      (rom_col),
      .o_last     (w_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rom_ch    <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_done      <= 1'b0;
         r_cmd_err   <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_cmd_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  if (w_bad) begin
                     r_cmd_err <= 1'b1;
                  end else begin
                     r_rom_ch <= cmd_ch;
                     r_state  <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (w_adv) begin
                  r_out_data  <= rom_data;
                  r_out_valid <= 1'b1;
                  r_out_last  <= w_last;
                  if (w_last) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (r_out_valid && out_ready) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
                  r_state     <= S_DONE;
               end
            end
            default: begin
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state == S_FETCH) || (r_state == S_DRAIN);
   assign rom_ch    = r_rom_ch;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign done      = r_done;
   assign cmd_err   = r_cmd_err;

`ifdef WEIGHT_FETCH_PERF_EN
   logic [31:0] r_perf_stall;
   logic [15:0] r_perf_tile;
   logic        w_stall;

   assign w_stall = busy && r_out_valid && !out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_perf_stall <= '0;
         r_perf_tile  <= '0;
      end else begin
         if (w_stall && (r_perf_stall != '1)) begin
            r_perf_stall <= r_perf_stall + 1'b1;
         end
         if (r_done && (r_perf_tile != '1)) begin
            r_perf_tile <= r_perf_tile + 1'b1;
         end
      end
   end

   assign perf_stall_cnt = r_perf_stall;
   assign perf_tile_cnt  = r_perf_tile;
`endif

endmodule

// File: tb/tb_weight_rom_fetch_sequencer.sv
// tb/tb_weight_rom_fetch_sequencer.sv - self-checking bench for weight_rom_fetch_sequencer
module tb_weight_rom_fetch_sequencer;
   import weight_fetch_pkg::*;

   localparam int ROWS = 64;
   localparam int COLS = 64;
   localparam int NUM_CH = 10;
   localparam int W = 32;
   localparam int A = 12;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [A-1:0] cmd_ch = '0;
   logic [A-1:0] cmd_row_base = '0;
   logic [A-1:0] cmd_col_base = '0;
   logic [A-1:0] cmd_rows = '0;
   logic [A-1:0] cmd_cols = '0;
   logic [A-1:0] rom_ch;
   logic [A-1:0] rom_row;
   logic [A-1:0] rom_col;
   logic [W-1:0] rom_data;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         done;
   logic         cmd_err;
   logic         busy;
`ifdef WEIGHT_FETCH_PERF_EN
   logic [31:0]  perf_stall_cnt;
   logic [15:0]  perf_tile_cnt;
`endif

   always #5 clk = ~clk;

   weight_rom_fetch_sequencer #(
      .ROWS(ROWS), .COLS(COLS), .NUM_CH(NUM_CH), .W(W), .A(A)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_ch       (cmd_ch),
      .cmd_row_base (cmd_row_base),
      .cmd_col_base (cmd_col_base),
      .cmd_rows     (cmd_rows),
      .cmd_cols     (cmd_cols),
      .rom_ch       (rom_ch),
      .rom_row      (rom_row),
      .rom_col      (rom_col),
      .rom_data     (rom_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .done         (done),
      .cmd_err      (cmd_err),
`ifdef WEIGHT_FETCH_PERF_EN
      .perf_stall_cnt (perf_stall_cnt),
      .perf_tile_cnt  (perf_tile_cnt),
`endif
      .busy         (busy)
   );

   // ROM contents: every address gets a distinct, recognisable word.
   function automatic logic [W-1:0] rom_fn(input int ch, input int row, input int col);
      logic [7:0] mix;
      mix = 8'(row * 5 + col * 3 + ch * 7) ^ 8'hC3;
      return {mix, 8'(ch), 8'(row), 8'(col)};
   endfunction

   assign rom_data = rom_fn(int'(rom_ch), int'(rom_row), int'(rom_col));

   typedef struct {
      int ch;
      int row;
      int col;
      bit last;
   } word_t;

   typedef enum {M_IDLE, M_FIRST, M_ACTIVE, M_POST1, M_POST2} mphase_t;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic tile_cmd_t mk(input int ch, input int rb, input int cb, input int r, input int c);
      tile_cmd_t t;
      t.ch = A'(ch);
      t.row_base = A'(rb);
      t.col_base = A'(cb);
      t.rows = A'(r);
      t.cols = A'(c);
      return t;
   endfunction

   function automatic bit cmd_bad(input tile_cmd_t c);
      return (int'(c.rows) == 0) || (int'(c.cols) == 0) || (int'(c.ch) >= NUM_CH) ||
             (int'(c.row_base) + int'(c.rows) > ROWS) ||
             (int'(c.col_base) + int'(c.cols) > COLS);
   endfunction

   // k-th word of a tile in row-major order.
   function automatic word_t word_at(input tile_cmd_t c, input int k);
      word_t w;
      int nc;
      nc = int'(c.cols);
      w.ch = int'(c.ch);
      w.row = int'(c.row_base) + k / nc;
      w.col = int'(c.col_base) + k % nc;
      w.last = (k == int'(c.rows) * nc - 1);
      return w;
   endfunction

   // ---------------- reference model + per-cycle compare ----------------
   int      cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mphase_t ph = M_IDLE;
   word_t   exp_q[$];
   bit      err_pend = 0;
   bit      chk_en = 0;
   bit      stall_prev = 0;
   logic [W-1:0] prev_data;
   logic    prev_last;
   int      acc_cyc = -1000;
   int      done_cyc = -1000;
   int      hs_cnt = 0;
   logic [W-1:0] last_hs_data;
   logic    last_hs_last;
   tile_cmd_t mc;
   word_t   mw;

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmd_ready", cmd_ready, (ph == M_IDLE || ph == M_POST2));
         check("busy", busy, (ph == M_FIRST || ph == M_ACTIVE));
         check("done", done, (ph == M_POST2));
         check("out_valid", out_valid, (ph == M_ACTIVE));
         check("cmd_err", cmd_err, err_pend);
         if (stall_prev) begin
            check("stall_hold_valid", out_valid, 1'b1);
            check("stall_hold_data", out_data, prev_data);
            check("stall_hold_last", out_last, prev_last);
         end
         if (ph == M_POST2 && done) done_cyc = cyc;
      end
      if (!rst_n) begin
         exp_q.delete();
         ph = M_IDLE;
         err_pend = 0;
         stall_prev = 0;
         chk_en = 1;
      end else begin
         err_pend = 0;
         stall_prev = out_valid && !out_ready;
         prev_data = out_data;
         prev_last = out_last;
         case (ph)
            M_IDLE, M_POST2: begin
               ph = M_IDLE;
               if (cmd_valid) begin
                  mc.ch = cmd_ch;
                  mc.row_base = cmd_row_base;
                  mc.col_base = cmd_col_base;
                  mc.rows = cmd_rows;
                  mc.cols = cmd_cols;
                  if (cmd_bad(mc)) begin
                     err_pend = 1;
                  end else begin
                     for (int k = 0; k < int'(mc.rows) * int'(mc.cols); k++)
                        exp_q.push_back(word_at(mc, k));
                     acc_cyc = cyc + 1;
                     ph = M_FIRST;
                  end
               end
            end
            M_FIRST: ph = M_ACTIVE;
            M_ACTIVE: begin
               if (out_valid && out_ready) begin
                  if (exp_q.size() == 0) begin
                     check("extra_word", 1'b1, 1'b0);
                  end else begin
                     mw = exp_q.pop_front();
                     check("out_data", out_data, rom_fn(mw.ch, mw.row, mw.col));
                     check("out_last", out_last, mw.last);
                     hs_cnt++;
                     last_hs_data = out_data;
                     last_hs_last = out_last;
                     if (mw.last) ph = M_POST1;
                  end
               end
            end
            default: ph = M_POST2;
         endcase
      end
   end

   // ---------------- out_ready driver ----------------
   int rmode = 0;
   always @(posedge clk) begin
      #1;
      case (rmode)
         1: out_ready = ($urandom_range(0, 99) < 65);
         2: out_ready = !((cyc - acc_cyc) >= 2 && (cyc - acc_cyc) <= 4);
         default: out_ready = 1'b1;
      endcase
   end

   // ---------------- stimulus ----------------
   task automatic send_cmd(input tile_cmd_t c);
      int t;
      @(posedge clk); #1;
      cmd_ch = c.ch;
      cmd_row_base = c.row_base;
      cmd_col_base = c.col_base;
      cmd_rows = c.rows;
      cmd_cols = c.cols;
      cmd_valid = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!cmd_ready && t < 200);
      if (t >= 200) check("cmd_accept_timeout", 1'b1, 1'b0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (!(ph == M_IDLE && !err_pend) && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 3000) check("idle_timeout", 1'b1, 1'b0);
   endtask

   tile_cmd_t basic;
   word_t     pw;
   int        hs0;
`ifdef WEIGHT_FETCH_PERF_EN
   logic [31:0] stall0;
`endif

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, n_errors=%0d", n_errors);
      $fatal(1);
   end

   initial begin
      basic = mk(1, 2, 3, 2, 3);
      // Pin the model's tile walk with hand-computed addresses.
      pw = word_at(basic, 0);
      check("pin_w0", {pw.ch, pw.row, pw.col}, {32'd1, 32'd2, 32'd3});
      pw = word_at(basic, 3);
      check("pin_w3", {pw.row, pw.col, 31'd0, pw.last}, {32'd3, 32'd3, 32'd0});
      pw = word_at(basic, 5);
      check("pin_w5", {pw.row, pw.col, 31'd0, pw.last}, {32'd3, 32'd5, 32'd1});
      check("pin_bad_cb60", cmd_bad(mk(0, 0, 60, 1, 5)), 1'b1);

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rom_ch", rom_ch, '0);
      check("rst_rom_row", rom_row, '0);
      check("rst_rom_col", rom_col, '0);
      check("rst_out_data", out_data, '0);
      check("rst_out_last", out_last, 1'b0);
      rst_n = 1'b1;

      // Basic tile, ready held high.
      rmode = 0;
      send_cmd(basic);
      wait_idle();
      check("basic_done_latency", done_cyc - acc_cyc, 8);

      // Backpressure: ready low in cycles 2..4 after acceptance.
`ifdef WEIGHT_FETCH_PERF_EN
      stall0 = perf_stall_cnt;
`endif
      rmode = 2;
      send_cmd(basic);
      wait_idle();
      rmode = 0;
`ifdef WEIGHT_FETCH_PERF_EN
      check("perf_stall", perf_stall_cnt - stall0, 3);
`endif

      // Corner 1x1 tile.
      send_cmd(mk(9, 63, 63, 1, 1));
      wait_idle();
      check("edge_data", last_hs_data, rom_fn(9, 63, 63));
      check("edge_last", last_hs_last, 1'b1);
      check("edge_done_latency", done_cyc - acc_cyc, 3);

      // Rejected commands.
      send_cmd(mk(0, 0, 0, 0, 4));
      wait_idle();
      send_cmd(mk(10, 0, 0, 2, 2));
      wait_idle();
      send_cmd(mk(0, 0, 60, 1, 5));
      wait_idle();

      // Reset after word 3 of a 4x4 tile, then a fresh tile.
      hs0 = hs_cnt;
      send_cmd(mk(3, 10, 20, 4, 4));
      while (hs_cnt - hs0 < 3 && ph != M_IDLE) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      send_cmd(mk(4, 5, 6, 3, 2));
      wait_idle();

      // Command presented while a tile is in flight must be ignored.
      send_cmd(mk(2, 0, 0, 2, 8));
      @(posedge clk); #1;
      cmd_ch = A'(5);
      cmd_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wait_idle();

      // Randomized commands with random backpressure.
      rmode = 1;
      for (int i = 0; i < 40; i++) begin
         send_cmd(mk($urandom_range(0, 11), $urandom_range(0, 63), $urandom_range(0, 63),
                     $urandom_range(0, 6), $urandom_range(0, 6)));
         wait_idle();
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      end
      for (int i = 0; i < 20; i++) begin
         send_cmd(mk($urandom_range(0, 9), $urandom_range(50, 63), $urandom_range(0, 60),
                     $urandom_range(1, 4), $urandom_range(1, 4)));
         wait_idle();
      end
      rmode = 0;
      repeat (4) @(posedge clk);
      #1;
      check("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
